// File: rtl/sequenciador_estados_if.sv
// Control/status bundle for sequenciador_estados.
// With SEQ_REVERSIVEL_EN defined, the bundle also carries the direction input 'sentido'.
interface sequenciador_estados_if #(
  parameter int N_ESTADOS = 3,
  parameter int W_TEMPO   = 8
);
  localparam int W_EST = ($clog2(N_ESTADOS) > 1) ? $clog2(N_ESTADOS) : 1;

  // No valid/ready pair: every control is a level sampled on each rising clk edge.
  // The priority order is limpa > avanca > (habilita and dwell expiry) > habilita.
  // Status outputs are registered, except saida_onehot, which decodes estado.
  logic                 limpa;
  logic                 habilita;
  logic                 avanca;
  logic [W_TEMPO-1:0]   tempo_estado;
`ifdef SEQ_REVERSIVEL_EN
  logic                 sentido;
`endif
  logic [W_EST-1:0]     estado;
  logic [N_ESTADOS-1:0] saida_onehot;
  logic [W_TEMPO-1:0]   contador;
  logic                 fim_ciclo;

`ifdef SEQ_REVERSIVEL_EN
  modport master (
    output limpa, habilita, avanca, tempo_estado, sentido,
    input  estado, saida_onehot, contador, fim_ciclo
  );
  modport slave (
    input  limpa, habilita, avanca, tempo_estado, sentido,
    output estado, saida_onehot, contador, fim_ciclo
  );
`else
  modport master (
    output limpa, habilita, avanca, tempo_estado,
    input  estado, saida_onehot, contador, fim_ciclo
  );
  modport slave (
    input  limpa, habilita, avanca, tempo_estado,
    output estado, saida_onehot, contador, fim_ciclo
  );
`endif
endinterface

// File: rtl/sequenciador_estados.sv
// N-state sequencer with a programmable dwell counter, forced advance and a wrap pulse.
// With SEQ_REVERSIVEL_EN defined, bus.sentido selects forward (0) or reverse (1) stepping.
module sequenciador_estados #(
  parameter int N_ESTADOS = 3,
  parameter int W_TEMPO   = 8
) (
  input  logic clk,
  input  logic rst_n,
  sequenciador_estados_if.slave bus
);
  localparam int W_EST = ($clog2(N_ESTADOS) > 1) ? $clog2(N_ESTADOS) : 1;
  localparam logic [W_EST-1:0] ULTIMO = W_EST'(N_ESTADOS - 1);

  typedef enum logic [1:0] {
    ACAO_RETEM,
    ACAO_CONTA,
    ACAO_AVANCA,
    ACAO_LIMPA
  } acao_t;

  acao_t                acao;
  logic [W_EST-1:0]     estado_q;
  logic [W_EST-1:0]     prox_estado;
  logic [W_TEMPO-1:0]   contador_q;
  logic                 fim_q;
  logic                 volta;
  logic                 expirou;
  logic [N_ESTADOS-1:0] onehot;

  // Live compare: a lowered tempo_estado lets the counter run round modulo 2^W_TEMPO.
  assign expirou = bus.habilita && (contador_q == bus.tempo_estado);

  always_comb begin : decide_acao
    acao = ACAO_RETEM;
    if (bus.limpa) begin
      acao = ACAO_LIMPA;
    end else if (bus.avanca || expirou) begin
      acao = ACAO_AVANCA;
    end else if (bus.habilita) begin
      acao = ACAO_CONTA;
    end
  end

  // Illegal encodings step to the entry state of the current direction without a wrap pulse.
  always_comb begin : calcula_proximo
    prox_estado = '0;
    volta       = 1'b0;
`ifdef SEQ_REVERSIVEL_EN
    if (bus.sentido) begin
      if (estado_q == '0) begin
        prox_estado = ULTIMO;
        volta       = 1'b1;
      end else if (estado_q <= ULTIMO) begin
        prox_estado = estado_q - W_EST'(1);
      end else begin
        prox_estado = ULTIMO;
      end
    end else begin
      if (estado_q == ULTIMO) begin
        prox_estado = '0;
        volta       = 1'b1;
      end else if (estado_q < ULTIMO) begin
        prox_estado = estado_q + W_EST'(1);
      end else begin
        prox_estado = '0;
      end
    end
`else
    if (estado_q == ULTIMO) begin
      prox_estado = '0;
      volta       = 1'b1;
    end else if (estado_q < ULTIMO) begin
      prox_estado = estado_q + W_EST'(1);
    end else begin
      prox_estado = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin : registra_estado
    if (!rst_n) begin
      estado_q   <= '0;
      contador_q <= '0;
      fim_q      <= 1'b0;
    end else begin
      case (acao)
        ACAO_LIMPA: begin
          estado_q   <= '0;
          contador_q <= '0;
          fim_q      <= 1'b0;
        end
        ACAO_AVANCA: begin
          estado_q   <= prox_estado;
          contador_q <= '0;
          fim_q      <= volta;
        end
        ACAO_CONTA: begin
          contador_q <= contador_q + W_TEMPO'(1);
          fim_q      <= 1'b0;
        end
        default: begin
          fim_q      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin : decodifica
    onehot = '0;
    for (int k = 0; k < N_ESTADOS; k++) begin
      if (estado_q == W_EST'(k)) onehot[k] = 1'b1;
    end
  end

  assign bus.estado       = estado_q;
  assign bus.saida_onehot = onehot;
  assign bus.contador     = contador_q;
  assign bus.fim_ciclo    = fim_q;
endmodule

// File: doc/sequenciador_estados.md
Name: sequenciador_estados

Overview:
- Parametrised state sequencer: internal dwell counter, binary state register, and a one-hot decoded enable per state.
- Generalises the fixed 2-bit / 3-output state decoder to N states, adding programmable dwell time, hold, forced advance and a cycle-wrap pulse.
- Drives the per-state enable lines of the datapath, e.g. light phases or mux selects.

Parameters:
N_ESTADOS, 3, number of states in the sequence (>=2); states 0..N_ESTADOS-1.
W_TEMPO, 8, width of the dwell counter and of tempo_estado.
W_EST (localparam), max(1,$clog2(N_ESTADOS)), width of the binary state output.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
limpa  input  1  synchronous clear: state and counter to 0.
habilita  input  1  dwell counter runs while high; state and counter freeze while low.
avanca  input  1  force advance to the next state on this edge.
tempo_estado  input  W_TEMPO  dwell length; state lasts tempo_estado+1 enabled cycles.
estado  output  W_EST  current state, binary, registered.
saida_onehot  output  N_ESTADOS  bit k high iff estado==k; combinational decode of the estado register.
contador  output  W_TEMPO  current dwell count, registered.
fim_ciclo  output  1  one-cycle registered pulse when the sequence wraps.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: estado=0, contador=0, fim_ciclo=0, saida_onehot=1 (bit 0 only).
- Priority each rising edge, highest first:
  - limpa: estado<=0, contador<=0, fim_ciclo<=0.
  - avanca: estado<=next(estado), contador<=0. Acts regardless of habilita.
  - habilita && contador==tempo_estado: estado<=next(estado), contador<=0.
  - habilita: contador<=contador+1.
  - otherwise: hold all registers.
- next(s) = s+1, with N_ESTADOS-1 -> 0.
- fim_ciclo:
  - <=1 on the edge where an advance (forced or expiry) takes estado from N_ESTADOS-1 to 0; otherwise <=0.
  - Visible in the same cycle estado first reads 0.
- tempo_estado==0 with habilita held high: advance every cycle.
- tempo_estado is sampled live. Lowering it below the current contador means no match until contador wraps modulo 2^W_TEMPO; this wrap is allowed and not an error.
- contador increments modulo 2^W_TEMPO and never saturates.
- Unreachable encodings (N_ESTADOS not a power of 2, or upset): next(s)=0, saida_onehot=all zeros, fim_ciclo=0 on that transition.
- saida_onehot has zero latency relative to estado and is exactly one-hot for all legal states.
- rst_n asserted mid-dwell: immediate return to reset values, with no fim_ciclo pulse.
- Latency: avanca or expiry sampled on edge n gives the new estado and saida_onehot after edge n.

Optional Feature:
- Macro: SEQ_REVERSIVEL_EN.
- Defined:
  - Adds port "sentido input 1" (0 = forward, 1 = reverse).
  - In reverse, next(s)=s-1, with 0 -> N_ESTADOS-1; unreachable encodings go to N_ESTADOS-1.
  - fim_ciclo pulses on the 0 -> N_ESTADOS-1 transition in reverse.
  - sentido may change any cycle and takes effect on the next advance.
- Not defined: no sentido port; forward only, exactly as above.

Test Plan:
- Reset release, N_ESTADOS=3, tempo_estado=2, habilita=1 -> estado 0,0,0,1,1,1,2,2,2,0; saida_onehot 001,010,100; fim_ciclo high exactly in the cycle estado returns to 0.
- habilita dropped at contador=1 for 5 cycles -> estado and contador frozen at 1; resume completes the remaining 2 cycles before advancing.
- avanca pulse at estado=2, contador=1, habilita=0 -> estado=0, contador=0, fim_ciclo=1 for one cycle.
- limpa and avanca together at estado=1 -> estado=0, contador=0, no fim_ciclo.
- rst_n low asynchronously mid-cycle at estado=2 -> outputs reset immediately, before the next clk edge.
- With SEQ_REVERSIVEL_EN, sentido=1, tempo_estado=0 -> estado 0,2,1,0,2; fim_ciclo on each 0->2 transition.
